// File: rtl/arq_hamming_sender.sv
// Transmit side of the nibble ARQ link: Hamming(7,4)-encodes a host nibble,
// sends it, and retransmits on nack or timeout until acked or retries run out.
module arq_hamming_sender #(
    parameter int unsigned MAX_RETRY = 3,
    parameter int unsigned TIMEOUT   = 15,
    parameter int unsigned TW        = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [3:0] in_data,
    output logic       in_ready,
    output logic       tx_valid,
    output logic [6:0] tx_code,
    input  logic       ack,
    input  logic       nack,
    output logic       done_ok,
    output logic       done_fail,
    output logic [2:0] retry_cnt
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [2:0]    RETRY_LAST = 3'(MAX_RETRY);

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [TW-1:0] timer;
    logic          accept;
    logic          got_ack;
    logic          attempt_failed;
    logic          retries_left;

    // Bit i of the codeword is Hamming position i+1; parity at positions 1, 2, 4.
    function automatic logic [6:0] hamming_encode(input logic [3:0] d);
        logic [6:0] c;
        c[0] = d[0] ^ d[1] ^ d[3];
        c[1] = d[0] ^ d[2] ^ d[3];
        c[2] = d[0];
        c[3] = d[1] ^ d[2] ^ d[3];
        c[4] = d[1];
        c[5] = d[2];
        c[6] = d[3];
        return c;
    endfunction

    assign in_ready = (state == ST_IDLE);
    assign tx_valid = (state == ST_SEND);
    assign accept   = in_valid & in_ready;

    // ack outranks nack; a silent WAIT expires on its last timer value.
    assign got_ack        = (state == ST_WAIT) && ack;
    assign attempt_failed = (state == ST_WAIT) && !ack && (nack || (timer == TIMER_LAST));
    assign retries_left   = (retry_cnt != RETRY_LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (got_ack) begin
                    state_nxt = ST_IDLE;
                end else if (attempt_failed) begin
                    state_nxt = retries_left ? ST_SEND : ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            tx_code   <= '0;
            retry_cnt <= '0;
            timer     <= '0;
            done_ok   <= 1'b0;
            done_fail <= 1'b0;
        end else begin
            state     <= state_nxt;
            done_ok   <= got_ack;
            done_fail <= attempt_failed && !retries_left;

            if (accept) begin
                tx_code   <= hamming_encode(in_data);
                retry_cnt <= '0;
            end else if (attempt_failed && retries_left) begin
                retry_cnt <= retry_cnt + 3'd1;
            end

            if (state == ST_SEND) begin
                timer <= '0;
            end else if (state == ST_WAIT) begin
                timer <= timer + TW'(1);
            end
        end
    end

endmodule

// File: tb/tb_arq_hamming_sender.sv
// Self-checking bench for arq_hamming_sender: scripted and randomized ARQ
// transactions compared against a positional Hamming / attempt-count model.
module tb_arq_hamming_sender;

    localparam int unsigned MAX_RETRY = 3;
    localparam int unsigned TIMEOUT   = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] in_data = '0;
    logic       in_ready;
    logic       tx_valid;
    logic [6:0] tx_code;
    logic       ack = 1'b0;
    logic       nack = 1'b0;
    logic       done_ok;
    logic       done_fail;
    logic [2:0] retry_cnt;

    arq_hamming_sender #(.MAX_RETRY(MAX_RETRY), .TIMEOUT(TIMEOUT), .TW(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .tx_valid(tx_valid), .tx_code(tx_code),
        .ack(ack), .nack(nack), .done_ok(done_ok), .done_fail(done_fail),
        .retry_cnt(retry_cnt)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Response plan per attempt: bit0 = ack, bit1 = nack, 0 = stay silent.
    logic [1:0]  plan_resp [8];
    int unsigned plan_dly  [8];

    int unsigned obs_sends, obs_oks, obs_fails, acc_cyc, done_cyc;
    logic [6:0]  obs_code [8];
    int unsigned obs_cyc  [8];
    logic [2:0]  obs_rc;
    bit          obs_hung;

    int unsigned e_sends, e_lat;
    bit          e_ok;
    logic [2:0]  e_rc;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Data bits fill non-power-of-two positions in order; parity p covers positions with bit p set.
    function automatic logic [6:0] ref_encode(input logic [3:0] d);
        logic [7:1]  cw;
        int unsigned k;
        logic        par;
        cw = '0;
        k  = 0;
        for (int unsigned pos = 1; pos <= 7; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                cw[pos] = d[k];
                k++;
            end
        end
        for (int unsigned p = 1; p <= 4; p = p * 2) begin
            par = 1'b0;
            for (int unsigned pos = 1; pos <= 7; pos++)
                if ((pos & p) != 0 && pos != p) par = par ^ cw[pos];
            cw[p] = par;
        end
        return cw;
    endfunction

    function automatic int unsigned ref_gap(input int unsigned a);
        return (plan_resp[a] == 2'd0) ? TIMEOUT + 1 : plan_dly[a] + 2;
    endfunction

    task automatic model_txn();
        e_sends = 0;
        e_ok    = 1'b0;
        e_rc    = '0;
        e_lat   = 0;
        for (int unsigned a = 0; a <= MAX_RETRY; a++) begin
            e_sends = a + 1;
            e_rc    = 3'(a);
            e_lat   = ref_gap(a);
            if (plan_resp[a][0]) begin
                e_ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic clear_plan();
        for (int i = 0; i < 8; i++) begin
            plan_resp[i] = 2'd0;
            plan_dly[i]  = 0;
        end
    endtask

    // Offers d, then answers each WAIT per the plan until the DUT returns to IDLE.
    task automatic run_txn(input logic [3:0] d);
        int unsigned wcnt, budget, a;
        obs_sends = 0; obs_oks = 0; obs_fails = 0; obs_hung = 1'b0;
        obs_rc = '0; wcnt = 0; budget = 0; done_cyc = 0;
        for (int i = 0; i < 8; i++) begin
            obs_code[i] = '0;
            obs_cyc[i]  = 0;
        end
        in_data  = d;
        in_valid = 1'b1;
        acc_cyc  = cyc;
        step();
        in_valid = 1'b0;
        while (1) begin
            in_data = 4'($urandom);
            ack  = 1'b0;
            nack = 1'b0;
            if (budget > 400) begin
                obs_hung = 1'b1;
                break;
            end
            budget++;
            if (done_ok)   obs_oks++;
            if (done_fail) obs_fails++;
            if (tx_valid) begin
                if (obs_sends < 8) begin
                    obs_code[obs_sends] = tx_code;
                    obs_cyc[obs_sends]  = cyc;
                end
                obs_sends++;
                wcnt = 0;
                {nack, ack} = 2'($urandom);
            end else if (in_ready) begin
                obs_rc   = retry_cnt;
                done_cyc = cyc;
                break;
            end else begin
                a = (obs_sends == 0) ? 0 : ((obs_sends > 8) ? 7 : obs_sends - 1);
                if (plan_resp[a] != 2'd0 && wcnt == plan_dly[a]) {nack, ack} = plan_resp[a];
                wcnt++;
            end
            step();
        end
        ack  = 1'b0;
        nack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_checks++; if (in_ready !== 1'b1)  $display("FAIL reset_in_ready: got %b want 1", in_ready); else n_pass++;
        n_checks++; if (tx_valid !== 1'b0)  $display("FAIL reset_tx_valid: got %b want 0", tx_valid); else n_pass++;
        n_checks++; if (tx_code !== 7'h00)  $display("FAIL reset_tx_code: got %h want 00", tx_code); else n_pass++;
        n_checks++; if (done_ok !== 1'b0)   $display("FAIL reset_done_ok: got %b want 0", done_ok); else n_pass++;
        n_checks++; if (done_fail !== 1'b0) $display("FAIL reset_done_fail: got %b want 0", done_fail); else n_pass++;
        n_checks++; if (retry_cnt !== 3'd0) $display("FAIL reset_retry_cnt: got %0d want 0", retry_cnt); else n_pass++;
        rst = 1'b0;
        step();
    endtask

    task automatic test_fast_ack();
        clear_plan();
        plan_resp[0] = 2'd1;
        run_txn(4'hB);
        n_checks++; if (obs_hung !== 1'b0)   $display("FAIL fast_ack_hung: got %b want 0", obs_hung); else n_pass++;
        n_checks++; if (obs_sends != 1)      $display("FAIL fast_ack_sends: got %0d want 1", obs_sends); else n_pass++;
        n_checks++; if (obs_cyc[0] != acc_cyc + 1) $display("FAIL fast_ack_tx_latency: got %0d want 1", obs_cyc[0] - acc_cyc); else n_pass++;
        n_checks++; if (obs_code[0] !== 7'h55) $display("FAIL fast_ack_code: got %h want 55", obs_code[0]); else n_pass++;
        n_checks++; if (done_cyc != obs_cyc[0] + 2) $display("FAIL fast_ack_done_latency: got %0d want 2", done_cyc - obs_cyc[0]); else n_pass++;
        n_checks++; if (obs_oks != 1 || obs_fails != 0) $display("FAIL fast_ack_done: got ok=%0d fail=%0d want ok=1 fail=0", obs_oks, obs_fails); else n_pass++;
        n_checks++; if (obs_rc !== 3'd0)     $display("FAIL fast_ack_retry_cnt: got %0d want 0", obs_rc); else n_pass++;
        n_checks++; if (in_ready !== 1'b1)   $display("FAIL fast_ack_in_ready: got %b want 1", in_ready); else n_pass++;
    endtask

    task automatic test_encoding();
        logic [3:0] d;
        for (int unsigned i = 0; i < 16; i++) begin
            d = 4'(i);
            clear_plan();
            plan_resp[0] = 2'd1;
            plan_dly[0]  = $urandom_range(0, 4);
            run_txn(d);
            n_checks++; if (obs_code[0] !== ref_encode(d)) $display("FAIL encode_%0h: got %h want %h", d, obs_code[0], ref_encode(d)); else n_pass++;
            if (d == 4'h0) begin
                n_checks++; if (obs_code[0] !== 7'h00) $display("FAIL encode_zero: got %h want 00", obs_code[0]); else n_pass++;
            end
            if (d == 4'hF) begin
                n_checks++; if (obs_code[0] !== 7'h7F) $display("FAIL encode_ones: got %h want 7f", obs_code[0]); else n_pass++;
            end
            n_checks++; if (obs_oks != 1 || obs_sends != 1) $display("FAIL encode_txn_%0h: got ok=%0d sends=%0d want ok=1 sends=1", d, obs_oks, obs_sends); else n_pass++;
        end
    endtask

    task automatic test_retries_success();
        clear_plan();
        plan_resp[0] = 2'd2; plan_dly[0] = 1;
        plan_resp[1] = 2'd2; plan_dly[1] = 3;
        plan_resp[2] = 2'd1; plan_dly[2] = 0;
        model_txn();
        run_txn(4'h3);
        n_checks++; if (obs_sends != e_sends) $display("FAIL retry_ok_sends: got %0d want %0d", obs_sends, e_sends); else n_pass++;
        for (int unsigned a = 0; a < 3; a++) begin
            n_checks++; if (obs_code[a] !== ref_encode(4'h3)) $display("FAIL retry_ok_code_%0d: got %h want %h", a, obs_code[a], ref_encode(4'h3)); else n_pass++;
        end
        for (int unsigned a = 0; a < 2; a++) begin
            n_checks++; if (obs_cyc[a+1] - obs_cyc[a] != ref_gap(a)) $display("FAIL retry_ok_gap_%0d: got %0d want %0d", a, obs_cyc[a+1] - obs_cyc[a], ref_gap(a)); else n_pass++;
        end
        n_checks++; if (obs_rc !== e_rc) $display("FAIL retry_ok_retry_cnt: got %0d want %0d", obs_rc, e_rc); else n_pass++;
        n_checks++; if (obs_oks != 1 || obs_fails != 0) $display("FAIL retry_ok_done: got ok=%0d fail=%0d want ok=1 fail=0", obs_oks, obs_fails); else n_pass++;
    endtask

    task automatic test_exhaustion();
        clear_plan();
        for (int unsigned a = 0; a <= MAX_RETRY; a++) begin
            plan_resp[a] = 2'd2;
            plan_dly[a]  = $urandom_range(0, 6);
        end
        model_txn();
        run_txn(4'h9);
        n_checks++; if (obs_sends != MAX_RETRY + 1) $display("FAIL exhaust_sends: got %0d want %0d", obs_sends, MAX_RETRY + 1); else n_pass++;
        n_checks++; if (obs_fails != 1 || obs_oks != 0) $display("FAIL exhaust_done: got ok=%0d fail=%0d want ok=0 fail=1", obs_oks, obs_fails); else n_pass++;
        n_checks++; if (obs_rc !== 3'(MAX_RETRY)) $display("FAIL exhaust_retry_cnt: got %0d want %0d", obs_rc, MAX_RETRY); else n_pass++;
        n_checks++; if (done_cyc - obs_cyc[MAX_RETRY] != e_lat) $display("FAIL exhaust_done_latency: got %0d want %0d", done_cyc - obs_cyc[MAX_RETRY], e_lat); else n_pass++;
        step();
        n_checks++; if (done_fail !== 1'b0 || in_ready !== 1'b1) $display("FAIL exhaust_after: got done_fail=%b in_ready=%b want 0 1", done_fail, in_ready); else n_pass++;
        n_checks++; if (retry_cnt !== 3'(MAX_RETRY)) $display("FAIL exhaust_retry_hold: got %0d want %0d", retry_cnt, MAX_RETRY); else n_pass++;
    endtask

    task automatic test_timeout();
        clear_plan();
        model_txn();
        run_txn(4'h6);
        n_checks++; if (obs_sends != e_sends) $display("FAIL timeout_sends: got %0d want %0d", obs_sends, e_sends); else n_pass++;
        for (int unsigned a = 0; a < MAX_RETRY; a++) begin
            n_checks++; if (obs_cyc[a+1] - obs_cyc[a] != TIMEOUT + 1) $display("FAIL timeout_gap_%0d: got %0d want %0d", a, obs_cyc[a+1] - obs_cyc[a], TIMEOUT + 1); else n_pass++;
        end
        n_checks++; if (obs_fails != 1 || obs_oks != 0) $display("FAIL timeout_done: got ok=%0d fail=%0d want ok=0 fail=1", obs_oks, obs_fails); else n_pass++;
        n_checks++; if (done_cyc - obs_cyc[MAX_RETRY] != TIMEOUT + 1) $display("FAIL timeout_done_latency: got %0d want %0d", done_cyc - obs_cyc[MAX_RETRY], TIMEOUT + 1); else n_pass++;
    endtask

    task automatic test_priority();
        clear_plan();
        plan_resp[0] = 2'd3;
        plan_dly[0]  = 2;
        run_txn(4'hC);
        n_checks++; if (obs_sends != 1) $display("FAIL priority_sends: got %0d want 1", obs_sends); else n_pass++;
        n_checks++; if (obs_oks != 1 || obs_fails != 0) $display("FAIL priority_done: got ok=%0d fail=%0d want ok=1 fail=0", obs_oks, obs_fails); else n_pass++;
        n_checks++; if (obs_rc !== 3'd0) $display("FAIL priority_retry_cnt: got %0d want 0", obs_rc); else n_pass++;
    endtask

    task automatic test_ack_in_idle();
        step();
        for (int unsigned i = 0; i < 5; i++) begin
            ack  = 1'b1;
            nack = 1'($urandom);
            step();
            n_checks++; if (done_ok !== 1'b0 || done_fail !== 1'b0 || in_ready !== 1'b1)
                $display("FAIL idle_ack_%0d: got ok=%b fail=%b in_ready=%b want 0 0 1", i, done_ok, done_fail, in_ready); else n_pass++;
        end
        ack  = 1'b0;
        nack = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        in_data  = 4'h5;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        nack = 1'b1;
        step();
        nack = 1'b0;
        n_checks++; if (tx_valid !== 1'b1 || retry_cnt !== 3'd1) $display("FAIL midrst_retry: got tx_valid=%b retry_cnt=%0d want 1 1", tx_valid, retry_cnt); else n_pass++;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++; if (in_ready !== 1'b1)  $display("FAIL midrst_in_ready: got %b want 1", in_ready); else n_pass++;
        n_checks++; if (retry_cnt !== 3'd0) $display("FAIL midrst_retry_cnt: got %0d want 0", retry_cnt); else n_pass++;
        n_checks++; if (tx_valid !== 1'b0)  $display("FAIL midrst_tx_valid: got %b want 0", tx_valid); else n_pass++;
        ack = 1'b1;
        step();
        ack = 1'b0;
        n_checks++; if (done_ok !== 1'b0 || done_fail !== 1'b0) $display("FAIL midrst_no_done: got ok=%b fail=%b want 0 0", done_ok, done_fail); else n_pass++;
        clear_plan();
        plan_resp[0] = 2'd1;
        run_txn(4'hB);
        n_checks++; if (obs_code[0] !== 7'h55 || obs_sends != 1) $display("FAIL midrst_resume: got code=%h sends=%0d want 55 1", obs_code[0], obs_sends); else n_pass++;
        n_checks++; if (obs_oks != 1 || obs_rc !== 3'd0) $display("FAIL midrst_resume_done: got ok=%0d rc=%0d want 1 0", obs_oks, obs_rc); else n_pass++;
    endtask

    task automatic test_random_back_to_back();
        logic [3:0] d;
        for (int unsigned t = 0; t < 25; t++) begin
            d = 4'($urandom);
            clear_plan();
            for (int unsigned a = 0; a <= MAX_RETRY; a++) begin
                plan_resp[a] = 2'($urandom_range(0, 3));
                plan_dly[a]  = $urandom_range(0, TIMEOUT - 3);
            end
            model_txn();
            run_txn(d);
            n_checks++; if (obs_hung !== 1'b0) $display("FAIL rnd%0d_hung: got %b want 0", t, obs_hung); else n_pass++;
            n_checks++; if (obs_sends != e_sends) $display("FAIL rnd%0d_sends: got %0d want %0d", t, obs_sends, e_sends); else n_pass++;
            n_checks++; if (obs_cyc[0] != acc_cyc + 1) $display("FAIL rnd%0d_tx_latency: got %0d want 1", t, obs_cyc[0] - acc_cyc); else n_pass++;
            for (int unsigned a = 0; a < e_sends && a < obs_sends && a < 8; a++) begin
                n_checks++; if (obs_code[a] !== ref_encode(d)) $display("FAIL rnd%0d_code_%0d: got %h want %h", t, a, obs_code[a], ref_encode(d)); else n_pass++;
                if (a + 1 < e_sends && a + 1 < obs_sends) begin
                    n_checks++; if (obs_cyc[a+1] - obs_cyc[a] != ref_gap(a)) $display("FAIL rnd%0d_gap_%0d: got %0d want %0d", t, a, obs_cyc[a+1] - obs_cyc[a], ref_gap(a)); else n_pass++;
                end
            end
            n_checks++; if (obs_oks != (e_ok ? 1 : 0) || obs_fails != (e_ok ? 0 : 1))
                $display("FAIL rnd%0d_done: got ok=%0d fail=%0d want ok=%0d fail=%0d", t, obs_oks, obs_fails, e_ok, !e_ok); else n_pass++;
            n_checks++; if (obs_rc !== e_rc) $display("FAIL rnd%0d_retry_cnt: got %0d want %0d", t, obs_rc, e_rc); else n_pass++;
            if (obs_sends >= 1 && obs_sends <= 8) begin
                n_checks++; if (done_cyc - obs_cyc[obs_sends-1] != e_lat) $display("FAIL rnd%0d_done_latency: got %0d want %0d", t, done_cyc - obs_cyc[obs_sends-1], e_lat); else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_fast_ack();
        test_encoding();
        test_retries_success();
        test_exhaustion();
        test_timeout();
        test_priority();
        test_ack_in_idle();
        test_reset_mid_wait();
        test_random_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d checks so far", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
